// File: rtl/control_unit.sv
// Hardwired microsequencer for the 8-bit accumulator CPU.
// Each instruction runs through a fixed T0..T3 ring. A programming mode bypasses
// sequencing and decodes memory-load commands straight from the switch input.
module control_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic [8:0] instin,
   input  logic       pmode,
   output logic       pc_inc,
   output logic       pc_ld,
   output logic       mar_ld,
   output logic       ram_we,
   output logic       ram_oe,
   output logic       ir_ld,
   output logic       ir_oe,
   output logic       acc_ld,
   output logic       acc_oe,
   output logic       b_ld,
   output logic       alu_sub,
   output logic       alu_oe,
   output logic       out_ld,
   output logic       flag_ld,
   output logic       prog_we,
   output logic       halt
);

   typedef enum logic [2:0] {
      T0   = 3'd0,
      T1   = 3'd1,
      T2   = 3'd2,
      T3   = 3'd3,
      HALT = 3'd4
   } state_t;

   localparam logic [3:0] OP_LDA = 4'b0001;
   localparam logic [3:0] OP_STA = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_LDB = 4'b0101;
   localparam logic [3:0] OP_LDI = 4'b1000;
   localparam logic [3:0] OP_OUT = 4'b1010;
   localparam logic [3:0] OP_JMP = 4'b1011;
   localparam logic [3:0] OP_HLT = 4'b1111;

   state_t     state;
   state_t     next;
   logic [3:0] ir_q;

   // State register and opcode latch; the opcode is captured on the edge leaving T1 in run mode only
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= T0;
         ir_q  <= 4'b0000;
      end else begin
         state <= next;
         if (!pmode && state == T1) begin
            ir_q <= instin[3:0];
         end
      end
   end

   // Next-state logic: program mode parks the ring at T0, HALT is sticky until program mode or reset
   always_comb begin
      next = T0;
      if (!pmode) begin
         case (state)
            T0:      next = T1;
            T1:      next = T2;
            T2:      next = (ir_q == OP_HLT) ? HALT : T3;
            T3:      next = T0;
            HALT:    next = HALT;
            default: next = T0;
         endcase
      end
   end

   // Strobe decode from state, latched opcode, mode and switch input; everything defaults low
   always_comb begin
      pc_inc  = 1'b0;
      pc_ld   = 1'b0;
      mar_ld  = 1'b0;
      ram_we  = 1'b0;
      ram_oe  = 1'b0;
      ir_ld   = 1'b0;
      ir_oe   = 1'b0;
      acc_ld  = 1'b0;
      acc_oe  = 1'b0;
      b_ld    = 1'b0;
      alu_sub = 1'b0;
      alu_oe  = 1'b0;
      out_ld  = 1'b0;
      flag_ld = 1'b0;
      prog_we = 1'b0;
      halt    = 1'b0;
      if (rst) begin
         pc_inc = 1'b0;
      end else if (pmode) begin
         case (instin[3:0])
            4'b0001: begin
               mar_ld  = 1'b1;
               prog_we = 1'b1;
            end
            4'b0010: pc_ld = 1'b1;
            default: pc_ld = 1'b0;
         endcase
      end else begin
         case (state)
            T0: mar_ld = 1'b1;
            T1: begin
               ram_oe = 1'b1;
               ir_ld  = 1'b1;
               pc_inc = 1'b1;
            end
            T2: begin
               case (ir_q)
                  OP_LDA, OP_STA, OP_LDB: begin
                     ir_oe  = 1'b1;
                     mar_ld = 1'b1;
                  end
                  OP_ADD: begin
                     alu_oe  = 1'b1;
                     acc_ld  = 1'b1;
                     flag_ld = 1'b1;
                  end
                  OP_SUB: begin
                     alu_sub = 1'b1;
                     alu_oe  = 1'b1;
                     acc_ld  = 1'b1;
                     flag_ld = 1'b1;
                  end
                  OP_LDI: begin
                     ir_oe  = 1'b1;
                     acc_ld = 1'b1;
                  end
                  OP_OUT: begin
                     acc_oe = 1'b1;
                     out_ld = 1'b1;
                  end
                  OP_JMP: begin
                     ir_oe = 1'b1;
                     pc_ld = 1'b1;
                  end
                  OP_HLT:  halt = 1'b1;
                  default: halt = 1'b0;
               endcase
            end
            T3: begin
               case (ir_q)
                  OP_LDA: begin
                     ram_oe = 1'b1;
                     acc_ld = 1'b1;
                  end
                  OP_STA: begin
                     acc_oe = 1'b1;
                     ram_we = 1'b1;
                  end
                  OP_LDB: begin
                     ram_oe = 1'b1;
                     b_ld   = 1'b1;
                  end
                  default: halt = 1'b0;
               endcase
            end
            HALT:    halt = 1'b1;
            default: halt = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit: walks instructions through the T-ring,
// exercises program mode, halt and aborts, checking all 16 strobes each step.
module tb_control_unit;

   logic       clk;
   logic       rst;
   logic [8:0] instin;
   logic       pmode;
   logic       pc_inc, pc_ld, mar_ld, ram_we, ram_oe, ir_ld, ir_oe, acc_ld;
   logic       acc_oe, b_ld, alu_sub, alu_oe, out_ld, flag_ld, prog_we, halt;

   int errors = 0;
   int checks = 0;

   localparam logic [15:0] NONE    = 16'h0000;
   localparam logic [15:0] PC_INC  = 16'h8000;
   localparam logic [15:0] PC_LD   = 16'h4000;
   localparam logic [15:0] MAR_LD  = 16'h2000;
   localparam logic [15:0] RAM_WE  = 16'h1000;
   localparam logic [15:0] RAM_OE  = 16'h0800;
   localparam logic [15:0] IR_LD   = 16'h0400;
   localparam logic [15:0] IR_OE   = 16'h0200;
   localparam logic [15:0] ACC_LD  = 16'h0100;
   localparam logic [15:0] ACC_OE  = 16'h0080;
   localparam logic [15:0] B_LD    = 16'h0040;
   localparam logic [15:0] ALU_SUB = 16'h0020;
   localparam logic [15:0] ALU_OE  = 16'h0010;
   localparam logic [15:0] OUT_LD  = 16'h0008;
   localparam logic [15:0] FLAG_LD = 16'h0004;
   localparam logic [15:0] PROG_WE = 16'h0002;
   localparam logic [15:0] HALT_B  = 16'h0001;
   localparam logic [15:0] FETCH   = RAM_OE | IR_LD | PC_INC;

   logic [15:0] outVec;
   assign outVec = {pc_inc, pc_ld, mar_ld, ram_we, ram_oe, ir_ld, ir_oe, acc_ld,
                    acc_oe, b_ld, alu_sub, alu_oe, out_ld, flag_ld, prog_we, halt};

   control_unit dut (
      .clk     (clk),
      .rst     (rst),
      .instin  (instin),
      .pmode   (pmode),
      .pc_inc  (pc_inc),
      .pc_ld   (pc_ld),
      .mar_ld  (mar_ld),
      .ram_we  (ram_we),
      .ram_oe  (ram_oe),
      .ir_ld   (ir_ld),
      .ir_oe   (ir_oe),
      .acc_ld  (acc_ld),
      .acc_oe  (acc_oe),
      .b_ld    (b_ld),
      .alu_sub (alu_sub),
      .alu_oe  (alu_oe),
      .out_ld  (out_ld),
      .flag_ld (flag_ld),
      .prog_we (prog_we),
      .halt    (halt)
   );

   // Free-running clock, 10 time-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] expected);
      #1;
      checks++;
      assert (outVec === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, outVec, expected);
      end
   endtask

   // Starting in T0 right after an edge: check T0, present the word in T1,
   // scramble instin afterwards so T2/T3 must come from the latched opcode.
   task automatic applyStimulus(input string tag, input logic [8:0] word,
                                input logic [15:0] expT2, input logic [15:0] expT3);
      checkOutput({tag, "_t0"}, MAR_LD);
      tick();
      instin = word;
      checkOutput({tag, "_t1"}, FETCH);
      tick();
      instin = 9'b000000000;
      checkOutput({tag, "_t2"}, expT2);
      tick();
      instin = 9'b111111111;
      checkOutput({tag, "_t3"}, expT3);
      tick();
   endtask

   initial begin
      rst    = 1'b1;
      pmode  = 1'b0;
      instin = 9'b000000000;

      tick();
      checkOutput("reset_c1", NONE);
      instin = 9'b000011111;
      pmode  = 1'b1;
      checkOutput("reset_pmode", NONE);
      pmode  = 1'b0;
      tick();
      checkOutput("reset_c2", NONE);
      rst = 1'b0;
      checkOutput("release_t0", MAR_LD);

      applyStimulus("add", 9'b001100011, ALU_OE | ACC_LD | FLAG_LD, NONE);
      applyStimulus("sub", 9'b010100100, ALU_SUB | ALU_OE | ACC_LD | FLAG_LD, NONE);
      applyStimulus("out", 9'b000001010, ACC_OE | OUT_LD, NONE);
      applyStimulus("jmp", 9'b000101011, IR_OE | PC_LD, NONE);
      applyStimulus("lda", 9'b000010001, IR_OE | MAR_LD, RAM_OE | ACC_LD);
      applyStimulus("sta", 9'b000110010, IR_OE | MAR_LD, ACC_OE | RAM_WE);
      applyStimulus("ldb", 9'b001000101, IR_OE | MAR_LD, RAM_OE | B_LD);
      applyStimulus("ldi", 9'b001111000, IR_OE | ACC_LD, NONE);
      applyStimulus("nop", 9'b000000000, NONE, NONE);
      applyStimulus("rsv1001", 9'b001001001, NONE, NONE);
      applyStimulus("rsv0110", 9'b000000110, NONE, NONE);

      // Program mode decodes the switches directly
      pmode  = 1'b1;
      instin = 9'b011010001;
      checkOutput("pm_load", MAR_LD | PROG_WE);
      tick();
      instin = 9'b000110010;
      checkOutput("pm_pcld", PC_LD);
      tick();
      instin = 9'b001001000;
      checkOutput("pm_other", NONE);
      tick();
      pmode  = 1'b0;
      instin = 9'b000000000;
      checkOutput("pm_exit_t0", MAR_LD);

      // Abort LDA in T2 with program mode, then resume from T0
      tick();
      instin = 9'b000010001;
      checkOutput("abort_t1", FETCH);
      tick();
      instin = 9'b000000000;
      pmode  = 1'b1;
      checkOutput("abort_pm", NONE);
      tick();
      pmode = 1'b0;
      applyStimulus("after_abort", 9'b000001010, ACC_OE | OUT_LD, NONE);

      // Reset in the middle of SUB
      tick();
      instin = 9'b010100100;
      checkOutput("rstmid_t1", FETCH);
      tick();
      rst = 1'b1;
      checkOutput("rstmid_t2", NONE);
      tick();
      rst = 1'b0;
      applyStimulus("after_rst", 9'b001100011, ALU_OE | ACC_LD | FLAG_LD, NONE);

      // Halt, held indefinitely, released by program mode
      checkOutput("hlt_t0", MAR_LD);
      tick();
      instin = 9'b000001111;
      checkOutput("hlt_t1", FETCH);
      tick();
      instin = 9'b000000000;
      checkOutput("hlt_t2", HALT_B);
      for (int i = 0; i < 11; i++) begin
         tick();
         instin = 9'(i);
         checkOutput("hlt_hold", HALT_B);
      end
      pmode  = 1'b1;
      instin = 9'b000000000;
      checkOutput("hlt_pm", NONE);
      tick();
      pmode = 1'b0;
      checkOutput("hlt_pm_exit", MAR_LD);

      // Halt again, released by reset
      tick();
      instin = 9'b111111111;
      checkOutput("hlt2_t1", FETCH);
      tick();
      instin = 9'b000000000;
      checkOutput("hlt2_t2", HALT_B);
      tick();
      checkOutput("hlt2_hold", HALT_B);
      rst = 1'b1;
      checkOutput("hlt2_rst", NONE);
      tick();
      rst = 1'b0;
      checkOutput("hlt2_rst_t0", MAR_LD);
      tick();
      checkOutput("hlt2_rst_t1", FETCH);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/control_unit.md
Name:
control_unit

Overview:
- Hardwired microsequencer for the 8-bit accumulator CPU.
- Steps each instruction through a fixed 4-phase ring (T0..T3) and drives 16 single-bit datapath control strobes.
- Also provides a programming mode (pmode=1) that bypasses sequencing and directly decodes memory-load commands from the instruction/switch input.

Parameters:
- None. Widths are fixed: instruction 9 bits, opcode instin[3:0], operand field instin[8:4].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- instin  input  9  instruction word. [3:0] is the opcode; [8:4] is the address/operand. Driven by RAM in run mode, by switches in program mode.
- pmode  input  1  1 = programming mode, 0 = run mode.
- pc_inc  output  1  increment program counter.
- pc_ld  output  1  load PC from bus.
- mar_ld  output  1  load memory address register from bus.
- ram_we  output  1  RAM write (run mode).
- ram_oe  output  1  RAM drives bus.
- ir_ld  output  1  load instruction register.
- ir_oe  output  1  IR operand field drives bus.
- acc_ld  output  1  load accumulator.
- acc_oe  output  1  accumulator drives bus.
- b_ld  output  1  load B register.
- alu_sub  output  1  ALU subtract (0 = add).
- alu_oe  output  1  ALU result drives bus.
- out_ld  output  1  load output port.
- flag_ld  output  1  latch ALU flags.
- prog_we  output  1  RAM write from switches (program mode).
- halt  output  1  CPU halted.

Behaviour:
- Clocking: one clock (clk); reset rst is synchronous and active-high.
- State register values: T0, T1, T2, T3, HALT. There is also an internal 4-bit opcode latch, ir_q.
- Reset: at a clk edge with rst=1, state<=T0 and ir_q<=0. While rst=1, all 16 outputs are forced to 0 combinationally.
- Outputs are a combinational decode of (state, ir_q, pmode, instin). Any signal not listed for a case is 0.
- Run-mode sequence, one phase per clock:
  - T0: mar_ld. Next state T1.
  - T1: ram_oe, ir_ld, pc_inc. ir_q<=instin[3:0] at the edge leaving T1. Next state T2.
  - T2, T3: per opcode in ir_q, below. After T3, next state is always T0. Every instruction takes exactly 4 cycles, except HLT.
- Opcode table, giving T2 signals / T3 signals:
  - 0000 NOP: none / none.
  - 0001 LDA: ir_oe, mar_ld / ram_oe, acc_ld.
  - 0010 STA: ir_oe, mar_ld / acc_oe, ram_we.
  - 0011 ADD: alu_oe, acc_ld, flag_ld / none.
  - 0100 SUB: alu_sub, alu_oe, acc_ld, flag_ld / none.
  - 0101 LDB: ir_oe, mar_ld / ram_oe, b_ld.
  - 1000 LDI: ir_oe, acc_ld / none.
  - 1010 OUT: acc_oe, out_ld / none.
  - 1011 JMP: ir_oe, pc_ld / none.
  - 1111 HLT: halt / (not reached). Next state after T2 is HALT.
  - All other opcodes are reserved and execute as NOP.
- HALT state: halt=1, all other outputs 0. The unit stays in HALT until rst=1 or pmode=1.
- Program mode (pmode=1):
  - At each edge, state<=T0 and ir_q is unchanged. The run-mode decode is suppressed.
  - Outputs decode instin directly and combinationally:
    - instin[3:0]=0001: mar_ld, prog_we.
    - instin[3:0]=0010: pc_ld.
    - Anything else: all 0.
  - halt=0 in program mode.
- pmode 1->0: the first run-mode cycle is T0.
- rst has priority over pmode. pmode has priority over HALT.
- Mid-instruction reset or pmode assertion aborts the instruction; no partial strobes persist.

Test Plan:
- Reset: rst=1 for 2 cycles -> all outputs 0. First cycle after release -> mar_ld=1 only. Next cycle -> ram_oe, ir_ld, pc_inc=1.
- ADD: run mode, instin=9'b001100011 latched in T1 -> T2 gives alu_oe=acc_ld=flag_ld=1, alu_sub=0. T3 gives all 0. Next cycle T0 gives mar_ld.
- SUB / OUT / JMP:
  - instin=9'b010100100 -> T2 alu_sub=alu_oe=acc_ld=flag_ld=1.
  - 9'b000001010 -> T2 acc_oe=out_ld=1.
  - 9'b000101011 -> T2 ir_oe=pc_ld=1.
- LDA: instin=9'b000010001 -> T2 ir_oe=mar_ld=1; T3 ram_oe=acc_ld=1. Reserved 9'b001001001 (opcode 1001) -> T2 and T3 all 0.
- Program mode: pmode=1 with instin=9'b011010001 -> mar_ld=prog_we=1. instin=9'b000110010 -> pc_ld=1 only. instin=9'b001001000 -> all 0. Drop pmode -> next cycle mar_ld (T0).
- Halt: execute opcode 1111 -> halt=1 from T2 onward, held for 10+ cycles. Then pmode=1 -> halt=0. Alternatively rst -> outputs 0, then T0.
